// File: rtl/enc_pkg.sv
// Shared definitions for the registered one-hot / priority encoder.
package enc_pkg;

    // Encoding modes, fixed per instance through the MODE parameter.
    localparam logic [1:0] ENC_STRICT = 2'd0;
    localparam logic [1:0] ENC_PRIO   = 2'd1;
    localparam logic [1:0] ENC_RR     = 2'd2;

    // Widest index needed for the largest legal request vector (N = 64).
    localparam int ENC_IDX_W = 6;

    typedef struct packed {
        logic [ENC_IDX_W-1:0] index;
        logic                 hit;
        logic                 multi;
    } enc_result_t;

endpackage

// File: rtl/enc_prio_core.sv
// Combinational encode core: rotate by the start pointer, find the lowest set
// bit, then add the pointer back modulo N.
module enc_prio_core
    import enc_pkg::*;
#(
    parameter int N = 16,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    input  logic [1:0]   mode,
    output logic [W-1:0] index,
    output logic         hit,
    output logic         multi
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [W-1:0]   base;
    logic [W-1:0]   off;
    logic           found;
    logic [W:0]     sum;

    // Rotated LSB-first search; only round-robin uses a nonzero start.
    always_comb begin
        base  = (mode == ENC_RR) ? start : '0;
        dbl   = {vec, vec} >> base;
        rot   = dbl[N-1:0];
        found = 1'b0;
        off   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off   = W'(i);
            end
        end
        sum = {1'b0, off} + {1'b0, base};
        if (sum >= (W+1)'(N)) begin
            sum = sum - (W+1)'(N);
        end

        multi = |(vec & (vec - N'(1)));

        // Strict mode only grants a single set bit; the other modes grant any.
        if (mode == ENC_STRICT) begin
            hit = found && !multi;
        end else begin
            hit = found;
        end
        index = hit ? sum[W-1:0] : '0;
    end

endmodule

// File: rtl/enc_onehot_pipe.sv
// Registered one-hot / priority / round-robin encoder with valid/ready
// handshakes on both sides and a saturating error counter.
module enc_onehot_pipe
    import enc_pkg::*;
#(
    parameter int N     = 16,
    parameter int W     = $clog2(N),
    parameter int MODE  = 0,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     encoder_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     binary_out,
    output logic             out_hit,
    output logic             out_multi,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [1:0] MODE_L = MODE[1:0];

    logic [W-1:0] ptr;
    logic [W-1:0] c_idx;
    logic         c_hit;
    logic         c_multi;
    logic         accept;
    enc_result_t  nxt;
    enc_result_t  res_q;
    logic         is_err;
    logic         ptr_upd;
    logic [W-1:0] ptr_nxt;
    logic         unused_idx;

    // A held result may be replaced in the same cycle it is consumed.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    enc_prio_core #(
        .N (N),
        .W (W)
    ) u_core (
        .vec   (encoder_in),
        .start (ptr),
        .mode  (MODE_L),
        .index (c_idx),
        .hit   (c_hit),
        .multi (c_multi)
    );

    // Next result, error flag and pointer advance; a disabled beat is null.
    always_comb begin
        nxt     = '0;
        is_err  = 1'b0;
        ptr_upd = 1'b0;
        ptr_nxt = ptr;
        if (enable) begin
            nxt.index = ENC_IDX_W'(c_idx);
            nxt.hit   = c_hit;
            nxt.multi = c_multi;
            // A miss is an error in every mode: zero input, or multi-hot in strict.
            is_err    = !c_hit;
            if (MODE_L == ENC_RR && c_hit) begin
                ptr_upd = 1'b1;
                ptr_nxt = (c_idx == W'(N - 1)) ? '0 : c_idx + W'(1);
            end
        end
    end

    // Result register and its valid flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            res_q     <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            res_q     <= nxt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Round-robin search pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept && ptr_upd) begin
            ptr <= ptr_nxt;
        end
    end

    // Saturating error counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (accept && is_err && err_count != '1) begin
            err_count <= err_count + ERR_W'(1);
        end
    end

    assign binary_out = res_q.index[W-1:0];
    assign out_hit    = res_q.hit;
    assign out_multi  = res_q.multi;
    // Index bits above W are always zero.
    assign unused_idx = ^res_q.index;

endmodule

// File: tb/tb_enc_onehot_pipe.sv
// Directed bench for enc_onehot_pipe: strict, priority, round-robin (N=16 and
// N=12), a 2-bit saturating counter instance, backpressure and reset.
module tb_enc_onehot_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] encoder_in;

    logic       s_in_ready, s_valid, s_hit, s_multi;
    logic [3:0] s_bin;
    logic [7:0] s_err;
    logic       p_in_ready, p_valid, p_hit, p_multi;
    logic [3:0] p_bin;
    logic [7:0] p_err;
    logic       r_in_ready, r_valid, r_hit, r_multi;
    logic [3:0] r_bin;
    logic [7:0] r_err;
    logic       q_in_ready, q_valid, q_hit, q_multi;
    logic [3:0] q_bin;
    logic [7:0] q_err;
    logic       t_in_ready, t_valid, t_hit, t_multi;
    logic [3:0] t_bin;
    logic [1:0] t_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    enc_onehot_pipe #(.N(16), .MODE(0), .ERR_W(8)) u_strict (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid),
        .in_ready(s_in_ready), .encoder_in(encoder_in), .out_valid(s_valid),
        .out_ready(out_ready), .binary_out(s_bin), .out_hit(s_hit),
        .out_multi(s_multi), .err_count(s_err));

    enc_onehot_pipe #(.N(16), .MODE(1), .ERR_W(8)) u_prio (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid),
        .in_ready(p_in_ready), .encoder_in(encoder_in), .out_valid(p_valid),
        .out_ready(out_ready), .binary_out(p_bin), .out_hit(p_hit),
        .out_multi(p_multi), .err_count(p_err));

    enc_onehot_pipe #(.N(16), .MODE(2), .ERR_W(8)) u_rr (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid),
        .in_ready(r_in_ready), .encoder_in(encoder_in), .out_valid(r_valid),
        .out_ready(out_ready), .binary_out(r_bin), .out_hit(r_hit),
        .out_multi(r_multi), .err_count(r_err));

    enc_onehot_pipe #(.N(12), .MODE(2), .ERR_W(8)) u_rr12 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid),
        .in_ready(q_in_ready), .encoder_in(encoder_in[11:0]), .out_valid(q_valid),
        .out_ready(out_ready), .binary_out(q_bin), .out_hit(q_hit),
        .out_multi(q_multi), .err_count(q_err));

    enc_onehot_pipe #(.N(16), .MODE(0), .ERR_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid),
        .in_ready(t_in_ready), .encoder_in(encoder_in), .out_valid(t_valid),
        .out_ready(out_ready), .binary_out(t_bin), .out_hit(t_hit),
        .out_multi(t_multi), .err_count(t_err));

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("in_ready_in_reset", s_in_ready, 1);
        chk("valid_in_reset", s_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One beat presented for exactly one edge; consecutive calls are back-to-back.
    task automatic beat(input logic [15:0] v, input logic en);
        @(negedge clk);
        in_valid   = 1'b1;
        encoder_in = v;
        enable     = en;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    typedef struct {
        logic [15:0] vec;
        bit          prio;
        bit          rst_before;
        int          idx;
        bit          hit;
        bit          multi;
        int          err;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        encoder_in = '0;

        tbl[0] = '{16'h0001, 0, 0,  0, 1, 0, 0};
        tbl[1] = '{16'h0400, 0, 0, 10, 1, 0, 0};
        tbl[2] = '{16'h8000, 0, 0, 15, 1, 0, 0};
        tbl[3] = '{16'h0000, 0, 0,  0, 0, 0, 1};
        tbl[4] = '{16'h0006, 0, 0,  0, 0, 1, 2};
        tbl[5] = '{16'hF0A0, 1, 1,  5, 1, 1, 0};
        tbl[6] = '{16'h8000, 1, 0, 15, 1, 0, 0};
        tbl[7] = '{16'h0000, 1, 0,  0, 0, 0, 1};
        tbl[8] = '{16'h0003, 1, 0,  0, 1, 1, 1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", s_valid, 0);
        chk("rst_binary_out", s_bin, 0);
        chk("rst_out_hit", s_hit, 0);
        chk("rst_out_multi", s_multi, 0);
        chk("rst_err_count", s_err, 0);
        chk("rst_in_ready", s_in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Strict then priority vectors, back-to-back with out_ready high.
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].rst_before) do_reset();
            beat(tbl[i].vec, 1'b1);
            if (tbl[i].prio) begin
                chk("prio_valid", p_valid, 1);
                chk("prio_index", p_bin, tbl[i].idx);
                chk("prio_hit", p_hit, tbl[i].hit);
                chk("prio_multi", p_multi, tbl[i].multi);
                chk("prio_err", p_err, tbl[i].err);
            end else begin
                chk("strict_valid", s_valid, 1);
                chk("strict_index", s_bin, tbl[i].idx);
                chk("strict_hit", s_hit, tbl[i].hit);
                chk("strict_multi", s_multi, tbl[i].multi);
                chk("strict_err", s_err, tbl[i].err);
            end
        end

        // Round-robin, N = 16: grants 0,4,15,0 and pointer 1,5,0,1.
        do_reset();
        begin
            int g[4];
            int p[4];
            g = '{0, 4, 15, 0};
            p = '{1, 5, 0, 1};
            for (int i = 0; i < 4; i++) begin
                beat(16'h8011, 1'b1);
                chk("rr_grant", r_bin, g[i]);
                chk("rr_hit", r_hit, 1);
                chk("rr_multi", r_multi, 1);
                chk("rr_ptr", u_rr.ptr, p[i]);
            end
            chk("rr_err", r_err, 0);
        end

        // Round-robin, N = 12: grant of N-1 wraps the pointer to 0.
        do_reset();
        begin
            int g[3];
            int p[3];
            g = '{0, 11, 0};
            p = '{1, 0, 1};
            for (int i = 0; i < 3; i++) begin
                beat(16'h0801, 1'b1);
                chk("rr12_grant", q_bin, g[i]);
                chk("rr12_ptr", u_rr12.ptr, p[i]);
            end
        end

        // Backpressure: three stalled cycles keep outputs frozen.
        do_reset();
        beat(16'h0010, 1'b1);
        chk("bp_first_index", s_bin, 4);
        @(negedge clk);
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        encoder_in = 16'h0020;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("bp_in_ready_low", s_in_ready, 0);
            chk("bp_valid_held", s_valid, 1);
            chk("bp_index_held", s_bin, 4);
            chk("bp_hit_held", s_hit, 1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_released_index", s_bin, 5);
        chk("bp_released_valid", s_valid, 1);

        // Toggling out_ready against a scoreboard of 12 one-hot beats.
        do_reset();
        begin
            int  sent = 0;
            int  got  = 0;
            bit  mv   = 0;
            bit  acc;
            for (int cyc = 0; cyc < 100 && got < 12; cyc++) begin
                @(negedge clk);
                out_ready  = ((cyc % 3) != 2) && ((cyc % 5) != 0);
                in_valid   = (sent < 12);
                encoder_in = 16'(1) << ((sent * 5) % 16);
                enable     = 1'b1;
                #1;
                chk("tog_in_ready", s_in_ready, (!mv) || out_ready);
                chk("tog_valid", s_valid, mv);
                if (mv && out_ready) begin
                    chk("tog_data", s_bin, (got * 5) % 16);
                    got++;
                end
                acc = in_valid && ((!mv) || out_ready);
                if (acc) begin
                    mv = 1'b1;
                    sent++;
                end else if (out_ready) begin
                    mv = 1'b0;
                end
            end
            chk("tog_count", got, 12);
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end

        // Saturation with a 2-bit counter.
        do_reset();
        begin
            int e[5];
            e = '{1, 2, 3, 3, 3};
            for (int i = 0; i < 5; i++) begin
                beat(16'h0000, 1'b1);
                chk("sat_err", t_err, e[i]);
                chk("sat_hit", t_hit, 0);
            end
        end

        // Reset while a result is held and ptr = 7.
        do_reset();
        beat(16'h0000, 1'b1);
        beat(16'h0040, 1'b1);
        chk("pre_rst_ptr", u_rr.ptr, 7);
        chk("pre_rst_valid", r_valid, 1);
        chk("pre_rst_err", r_err, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", r_valid, 0);
        chk("mid_rst_index", r_bin, 0);
        chk("mid_rst_hit", r_hit, 0);
        chk("mid_rst_multi", r_multi, 0);
        chk("mid_rst_err", r_err, 0);
        chk("mid_rst_ptr", u_rr.ptr, 0);
        chk("mid_rst_in_ready", r_in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Disabled beats give null results without errors or pointer moves.
        beat(16'h0000, 1'b0);
        chk("dis_valid", s_valid, 1);
        chk("dis_hit", s_hit, 0);
        chk("dis_err", s_err, 0);
        beat(16'h0006, 1'b0);
        chk("dis_multi", s_multi, 0);
        chk("dis_err2", s_err, 0);
        beat(16'h0040, 1'b0);
        chk("dis_rr_index", r_bin, 0);
        chk("dis_rr_ptr", u_rr.ptr, 0);
        chk("dis_rr_err", r_err, 0);
        enable = 1'b1;

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
